// File: rtl/bcd_pkg.sv
// Shared types and helpers for the two-digit BCD counter.
package bcd_pkg;

  typedef enum logic {
    STATE_STOP = 1'b0,
    STATE_RUN  = 1'b1
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Counter width able to hold 0..div-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned div);
    return (div <= 32'd2) ? 32'd1 : 32'($clog2(div));
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Modulo-DIV divider emitting a one-cycle strobe on the last count of each period.
module tick_gen
  import bcd_pkg::*;
#(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic sync_clr,
  output logic tick
);

  localparam int unsigned W = cnt_width(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 32'd1);

  logic [W-1:0] cnt;

  // Count holds while disabled so a paused period resumes where it left off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (sync_clr) begin
      cnt <= '0;
    end else if (enable) begin
      if (cnt == LAST) cnt <= '0;
      else             cnt <= cnt + W'(1);
    end
  end

  // Strobe is decoded from the count so the consumer updates on the wrap edge.
  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/bcd_counter_0_99.sv
// Two-digit BCD up/down counter with run/stop control, synchronous clear,
// rollover pulse and a free-running digit-select toggle for the display mux.
module bcd_counter_0_99
  import bcd_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned TICK_HZ    = 1,
  parameter int unsigned REFRESH_HZ = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       up_down,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic       refreshcounter,
  output logic       rollover,
  output logic       running
);

  localparam int unsigned DIV     = CLK_HZ / TICK_HZ;
  localparam int unsigned REF_DIV = CLK_HZ / (32'd2 * REFRESH_HZ);

  state_e     state_q, state_d;
  logic       tick;
  logic       ref_tick;
  logic [3:0] digit1_d, digit2_d;
  logic       rollover_d;

  tick_gen #(.DIV(DIV)) u_prescaler (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (running),
    .sync_clr (clear),
    .tick     (tick)
  );

  tick_gen #(.DIV(REF_DIV)) u_refresh (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (1'b1),
    .sync_clr (1'b0),
    .tick     (ref_tick)
  );

  // State register; running mirrors the state from its own flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= STATE_STOP;
      running <= 1'b0;
    end else begin
      state_q <= state_d;
      running <= (state_d == STATE_RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_stop) begin
      state_d = (state_q == STATE_RUN) ? STATE_STOP : STATE_RUN;
    end
  end

  // Next-digit arithmetic; clear wins over a coincident tick.
  always_comb begin
    digit1_d   = digit1;
    digit2_d   = digit2;
    rollover_d = 1'b0;
    if (clear) begin
      digit1_d = 4'd0;
      digit2_d = 4'd0;
    end else if (tick) begin
      if (up_down) begin
        if (digit1 >= BCD_MAX) begin
          digit1_d = 4'd0;
          if (digit2 >= BCD_MAX) begin
            digit2_d   = 4'd0;
            rollover_d = 1'b1;
          end else begin
            digit2_d = digit2 + 4'd1;
          end
        end else begin
          digit1_d = digit1 + 4'd1;
        end
      end else begin
        if (digit1 == 4'd0) begin
          digit1_d = BCD_MAX;
          if (digit2 == 4'd0) begin
            digit2_d   = BCD_MAX;
            rollover_d = 1'b1;
          end else begin
            digit2_d = digit2 - 4'd1;
          end
        end else begin
          digit1_d = digit1 - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit1   <= 4'd0;
      digit2   <= 4'd0;
      rollover <= 1'b0;
    end else begin
      digit1   <= digit1_d;
      digit2   <= digit2_d;
      rollover <= rollover_d;
    end
  end

  // Digit-select toggles on every refresh wrap, independent of clear and run state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      refreshcounter <= 1'b0;
    end else if (ref_tick) begin
      refreshcounter <= ~refreshcounter;
    end
  end

endmodule

// File: tb/tb_bcd_counter_0_99.sv
// Directed self-checking bench for bcd_counter_0_99 with DIV=10, REF_DIV=2.
module tb_bcd_counter_0_99;

  logic       clk;
  logic       reset_n;
  logic       start_stop;
  logic       clear;
  logic       up_down;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic       refreshcounter;
  logic       rollover;
  logic       running;

  int tests;
  int errors;

  bcd_counter_0_99 #(
    .CLK_HZ     (20),
    .TICK_HZ    (2),
    .REFRESH_HZ (5)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start_stop     (start_stop),
    .clear          (clear),
    .up_down        (up_down),
    .digit1         (digit1),
    .digit2         (digit2),
    .refreshcounter (refreshcounter),
    .rollover       (rollover),
    .running        (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    start_stop = 1'b0;
    clear      = 1'b0;
    up_down    = 1'b1;
    repeat (3) step();
    tests++;
    if ({digit2, digit1, refreshcounter, rollover, running} !== 11'd0) begin
      errors++;
      $display("FAIL reset_state: got d=%h rc=%b ro=%b run=%b, want all zero",
               {digit2, digit1}, refreshcounter, rollover, running);
    end
    reset_n = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      step();
      tests++;
      if ({digit2, digit1, rollover, running} !== 10'd0) begin
        errors++;
        $display("FAIL idle_hold cyc %0d: got d=%h ro=%b run=%b, want 00/0/0",
                 i, {digit2, digit1}, rollover, running);
      end
      tests++;
      if (refreshcounter !== 1'((i / 2) % 2)) begin
        errors++;
        $display("FAIL refresh_toggle cyc %0d: got %b want %b",
                 i, refreshcounter, 1'((i / 2) % 2));
      end
    end
  endtask

  task automatic test_count_up();
    up_down    = 1'b1;
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    tests++;
    if (running !== 1'b1 || {digit2, digit1} !== 8'h00) begin
      errors++;
      $display("FAIL start: got run=%b d=%h, want 1/00", running, {digit2, digit1});
    end
    for (int k = 1; k <= 105; k++) begin
      step();
      tests++;
      if ({digit2, digit1} !== bcd(k / 10) || rollover !== 1'b0) begin
        errors++;
        $display("FAIL count_up k=%0d: got d=%h ro=%b, want %h/0",
                 k, {digit2, digit1}, rollover, bcd(k / 10));
      end
    end
  endtask

  task automatic test_rollover_up();
    for (int k = 106; k <= 1005; k++) begin
      step();
      tests++;
      if ({digit2, digit1} !== bcd((k / 10) % 100) || rollover !== 1'(k == 1000)) begin
        errors++;
        $display("FAIL rollover_up k=%0d: got d=%h ro=%b, want %h/%b",
                 k, {digit2, digit1}, rollover, bcd((k / 10) % 100), 1'(k == 1000));
      end
    end
  endtask

  task automatic test_count_down();
    int exp;
    up_down = 1'b0;
    for (int k = 1006; k <= 1025; k++) begin
      step();
      exp = (k < 1010) ? 0 : (k < 1020) ? 99 : 98;
      tests++;
      if ({digit2, digit1} !== bcd(exp) || rollover !== 1'(k == 1010)) begin
        errors++;
        $display("FAIL count_down k=%0d: got d=%h ro=%b, want %h/%b",
                 k, {digit2, digit1}, rollover, bcd(exp), 1'(k == 1010));
      end
    end
    up_down = 1'b1;
  endtask

  task automatic test_stop_resume();
    clear = 1'b1;
    step();
    clear = 1'b0;
    tests++;
    if ({digit2, digit1} !== 8'h00 || running !== 1'b1 || rollover !== 1'b0) begin
      errors++;
      $display("FAIL clear_running: got d=%h run=%b ro=%b, want 00/1/0",
               {digit2, digit1}, running, rollover);
    end
    for (int j = 1; j <= 376; j++) begin
      step();
      tests++;
      if ({digit2, digit1} !== bcd(j / 10)) begin
        errors++;
        $display("FAIL after_clear j=%0d: got %h want %h", j, {digit2, digit1}, bcd(j / 10));
      end
    end
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    tests++;
    if (running !== 1'b0 || {digit2, digit1} !== 8'h37) begin
      errors++;
      $display("FAIL stop: got run=%b d=%h, want 0/37", running, {digit2, digit1});
    end
    for (int i = 0; i < 29; i++) begin
      step();
      tests++;
      if ({digit2, digit1} !== 8'h37 || running !== 1'b0) begin
        errors++;
        $display("FAIL stopped_hold cyc %0d: got d=%h run=%b, want 37/0",
                 i, {digit2, digit1}, running);
      end
    end
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    tests++;
    if (running !== 1'b1 || {digit2, digit1} !== 8'h37) begin
      errors++;
      $display("FAIL resume: got run=%b d=%h, want 1/37", running, {digit2, digit1});
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      tests++;
      if ({digit2, digit1} !== ((i == 3) ? 8'h38 : 8'h37)) begin
        errors++;
        $display("FAIL resume_partial cyc %0d: got %h want %h",
                 i, {digit2, digit1}, (i == 3) ? 8'h38 : 8'h37);
      end
    end
  endtask

  task automatic test_clear_tick();
    repeat (49) step();
    tests++;
    if ({digit2, digit1} !== 8'h42) begin
      errors++;
      $display("FAIL pre_clear: got %h want 42", {digit2, digit1});
    end
    clear      = 1'b1;
    start_stop = 1'b1;
    step();
    clear      = 1'b0;
    start_stop = 1'b0;
    tests++;
    if ({digit2, digit1} !== 8'h00 || rollover !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL clear_on_tick: got d=%h ro=%b run=%b, want 00/0/0",
               {digit2, digit1}, rollover, running);
    end
    for (int i = 0; i < 12; i++) begin
      step();
      tests++;
      if ({digit2, digit1} !== 8'h00 || rollover !== 1'b0) begin
        errors++;
        $display("FAIL cleared_hold cyc %0d: got d=%h ro=%b, want 00/0",
                 i, {digit2, digit1}, rollover);
      end
    end
  endtask

  task automatic test_async_reset();
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    repeat (25) step();
    tests++;
    if ({digit2, digit1} !== 8'h02 || running !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got d=%h run=%b, want 02/1", {digit2, digit1}, running);
    end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if ({digit2, digit1, refreshcounter, rollover, running} !== 11'd0) begin
      errors++;
      $display("FAIL async_reset: got d=%h rc=%b ro=%b run=%b, want all zero",
               {digit2, digit1}, refreshcounter, rollover, running);
    end
    step();
    reset_n = 1'b1;
    repeat (15) step();
    tests++;
    if ({digit2, digit1} !== 8'h00 || running !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got d=%h run=%b, want 00/0", {digit2, digit1}, running);
    end
    start_stop = 1'b1;
    step();
    start_stop = 1'b0;
    repeat (9) step();
    tests++;
    if ({digit2, digit1} !== 8'h00) begin
      errors++;
      $display("FAIL restart_early: got %h want 00", {digit2, digit1});
    end
    step();
    tests++;
    if ({digit2, digit1} !== 8'h01) begin
      errors++;
      $display("FAIL restart_first_tick: got %h want 01", {digit2, digit1});
    end
  endtask

  initial begin
    tests  = 0;
    errors = 0;
    test_reset();
    test_count_up();
    test_rollover_up();
    test_count_down();
    test_stop_resume();
    test_clear_tick();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
